// File: rtl/music_pkg.sv
// Shared constants, ROM field layout and sequencer state type for the
// song playback path (song_rom -> song_reader -> note_player).
package music_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;

  localparam int ADDR_W = SONG_W + IDX_W;
  localparam int ROM_W  = NOTE_W + DUR_W;

  // ROM word layout: {note[11:6], duration[5:0]}
  localparam int NOTE_LSB = 6;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_PLAYING,
    ST_DONE
  } sr_state_t;

endpackage

// File: rtl/song_reader_if.sv
// Signal bundle between song_reader and its environment: control inputs,
// song ROM read port and the note_player load/done handshake.
interface song_reader_if;
  import music_pkg::*;

  logic                play;
  logic [SONG_W-1:0]   song_sel;
  logic                note_done;
  logic [ADDR_W-1:0]   rom_addr;
  logic [ROM_W-1:0]    rom_data;
  logic [NOTE_W-1:0]   note;
  logic [DUR_W-1:0]    duration;
  logic                new_note;
  logic                song_done;

  modport master (
    input  play, song_sel, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    output play, song_sel, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_reader.sv
// Song sequencer: walks one song of a synchronous ROM, hands each entry to
// note_player with a one-cycle load strobe and waits for its done pulse.
// Handles pause, end-of-song markers and song reselection during playback.
module song_reader
  import music_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  song_reader_if.master bus
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  sr_state_t          state_q, state_d;
  logic [SONG_W-1:0]  song_q, song_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               pend_q, pend_d;

  logic               song_chg;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;

  assign song_chg = (bus.song_sel != song_q);
  assign rom_note = bus.rom_data[NOTE_LSB +: NOTE_W];
  assign rom_dur  = bus.rom_data[DUR_LSB +: DUR_W];

  // Outputs come straight from registers; the load strobe is dropped in the
  // LOAD cycle if a new song has just been requested.
  assign bus.rom_addr  = {song_q, idx_q};
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.new_note  = (state_q == ST_LOAD) && !song_chg;
  assign bus.song_done = (state_q == ST_DONE);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; a song change while active outranks every other exit.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    note_d  = note_q;
    dur_d   = dur_q;
    pend_d  = pend_q;

    if (state_q inside {ST_FETCH, ST_WAIT, ST_LOAD, ST_PLAYING} && song_chg) begin
      state_d = ST_FETCH;
      song_d  = bus.song_sel;
      idx_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d  = '0;
          song_d = bus.song_sel;
          if (bus.play) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          // Address is already on rom_addr; pausing here simply holds it.
          if (bus.play) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // Read data is valid now; completes even when paused.
          if (rom_dur == '0) begin
            state_d = ST_DONE;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_d = ST_PLAYING;
        end
        ST_PLAYING: begin
          // Remember a done pulse that arrives while paused.
          if (bus.note_done) pend_d = 1'b1;
          if ((bus.note_done || pend_q) && bus.play) begin
            pend_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          if (!bus.play || song_chg) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
